// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and duty slew helper for the PWM ramp controller
package pwm_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        IDLE = 2'd1,
        RAMP = 2'd2
    } pwm_state_t;

    // Widest duty the helper handles; callers zero-extend into it and truncate back.
    localparam int SAT_W = 16;
    typedef logic [SAT_W-1:0] sat_t;

    // Next duty on the way from cur to tgt, moving by at most step and never overshooting.
    // The distance is formed one bit wider so the subtraction cannot wrap.
    function automatic sat_t sat_step(input sat_t cur, input sat_t tgt, input sat_t step);
        logic [SAT_W:0] diff;
        sat_t           nxt;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            nxt  = (diff > {1'b0, step}) ? cur + step : tgt;
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
            nxt  = (diff > {1'b0, step}) ? cur - step : tgt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_core.sv
// rtl/pwm_ramp_ctrl_core.sv - period counter, period_end flag and duty compare
import pwm_pkg::*;

module pwm_core #(
    parameter int PERIOD = 10,
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DUTY_W-1:0] cur_duty,
    output logic              dout,
    output logic              period_end
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running period counter, parked at 0 whenever the block is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Output and period flag decode only from the counter and the applied duty register,
    // so duty updates landing on the wrap edge take effect cleanly at cnt=0.
    always_comb begin
        period_end = enable && (cnt == CNT_LAST);
        dout       = enable && (DUTY_W'(cnt) < cur_duty);
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - target handshake, slew FSM and PWM output stage
import pwm_pkg::*;

module pwm_ramp_ctrl #(
    parameter int PERIOD = 10,
    parameter int DUTY_W = 8,
    parameter int STEP   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              tgt_valid,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              tgt_ready,
    output logic              dout,
    output logic [DUTY_W-1:0] cur_duty,
    output logic              busy,
    output logic              period_end
);

    localparam logic [DUTY_W-1:0] PERIOD_D = DUTY_W'(PERIOD);

    pwm_state_t        state;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] clamped;
    logic [DUTY_W-1:0] nxt_duty;
    logic              accept;

    // Handshake decode, request clamp and the next slewed duty value.
    always_comb begin
        tgt_ready = enable && (state == IDLE);
        busy      = (state == RAMP);
        accept    = tgt_valid && tgt_ready;
        clamped   = (tgt_duty > PERIOD_D) ? PERIOD_D : tgt_duty;
        nxt_duty  = DUTY_W'(sat_step(sat_t'(cur_duty), sat_t'(target), sat_t'(STEP)));
    end

    // Sequencer: captures targets in IDLE, steps cur_duty only on period_end edges in RAMP.
    // Losing enable abandons everything and parks in OFF with duty cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= OFF;
            cur_duty <= '0;
            target   <= '0;
        end else if (!enable) begin
            state    <= OFF;
            cur_duty <= '0;
            target   <= '0;
        end else begin
            case (state)
                OFF: begin
                    state <= IDLE;
                end
                IDLE: begin
                    if (accept) begin
                        target <= clamped;
                        if (clamped != cur_duty) begin
                            state <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (period_end) begin
                        cur_duty <= nxt_duty;
                        if (nxt_duty == target) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

    pwm_core #(
        .PERIOD (PERIOD),
        .DUTY_W (DUTY_W)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cur_duty   (cur_duty),
        .dout       (dout),
        .period_end (period_end)
    );

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       tgt_valid = 1'b0;
    logic [7:0] tgt_duty = 8'd0;
    logic       tgt_ready;
    logic       dout;
    logic [7:0] cur_duty;
    logic       busy;
    logic       period_end;

    int vectors = 0;
    int miscompares = 0;

    pwm_ramp_ctrl #(
        .PERIOD (10),
        .DUTY_W (8),
        .STEP   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tgt_valid  (tgt_valid),
        .tgt_duty   (tgt_duty),
        .tgt_ready  (tgt_ready),
        .dout       (dout),
        .cur_duty   (cur_duty),
        .busy       (busy),
        .period_end (period_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance through the next period_end edge and land on the following negedge.
    task automatic wait_pe();
        int k = 0;
        while (!period_end && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!period_end) check("pe_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input int duty, input bit hold);
        int k = 0;
        while (!tgt_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", int'(tgt_ready), 1);
        tgt_valid = 1'b1;
        tgt_duty  = 8'(duty);
        @(posedge clk);
        @(negedge clk);
        if (!hold) tgt_valid = 1'b0;
    endtask

    task automatic ramp_steps(input int n, input int seq[6]);
        for (int i = 0; i < n; i++) begin
            wait_pe();
            check("ramp_duty", int'(cur_duty), seq[i]);
            if (i < n - 1) begin
                check("ramp_busy", int'(busy), 1);
            end else begin
                check("done_ready", int'(tgt_ready), 1);
                check("done_busy", int'(busy), 0);
            end
        end
    endtask

    // One full period of dout starting at cnt=0; bit i holds the value seen at cnt=i.
    task automatic dout_period(output int pat);
        pat = 0;
        wait_pe();
        for (int i = 0; i < 10; i++) begin
            if (dout) pat = pat | (1 << i);
            @(negedge clk);
        end
    endtask

    initial begin
        int pat;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dout", int'(dout), 0);
        check("rst_ready", int'(tgt_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pe", int'(period_end), 0);
        check("rst_duty", int'(cur_duty), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("off_ready", int'(tgt_ready), 0);
        check("off_dout", int'(dout), 0);

        // Ramp up 0 -> 6
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_ready", int'(tgt_ready), 1);
        accept(6, 1'b0);
        check("up_busy0", int'(busy), 1);
        check("up_ready0", int'(tgt_ready), 0);
        check("up_duty0", int'(cur_duty), 0);
        ramp_steps(3, '{2, 4, 6, 0, 0, 0});
        dout_period(pat);
        check("dout_six", pat, 63);

        // Ramp down with a partial last step 6 -> 1
        accept(1, 1'b0);
        ramp_steps(3, '{4, 2, 1, 0, 0, 0});

        // Clamp 15 -> 10, output then constant high
        accept(15, 1'b0);
        ramp_steps(5, '{3, 5, 7, 9, 10, 0});
        dout_period(pat);
        check("dout_full", pat, 1023);

        // Handshake stall: request held through a 10 -> 5 ramp
        accept(5, 1'b1);
        tgt_duty = 8'd3;
        check("stall_ready", int'(tgt_ready), 0);
        ramp_steps(3, '{8, 6, 5, 0, 0, 0});
        @(posedge clk);
        @(negedge clk);
        check("stall_taken", int'(busy), 1);
        check("stall_duty", int'(cur_duty), 5);
        tgt_valid = 1'b0;
        ramp_steps(1, '{3, 0, 0, 0, 0, 0});

        // Target equal to current duty stays idle
        accept(3, 1'b0);
        check("eq_busy", int'(busy), 0);
        check("eq_ready", int'(tgt_ready), 1);
        check("eq_duty", int'(cur_duty), 3);

        // Enable drop at cnt=4 mid-ramp 3 -> 9
        accept(9, 1'b0);
        wait_pe();
        check("drop_duty5", int'(cur_duty), 5);
        repeat (4) @(negedge clk);
        check("drop_dout_hi", int'(dout), 1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drop_duty", int'(cur_duty), 0);
        check("drop_dout", int'(dout), 0);
        check("drop_ready", int'(tgt_ready), 0);
        check("drop_busy", int'(busy), 0);
        check("drop_pe", int'(period_end), 0);
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reen_ready", int'(tgt_ready), 1);
        check("reen_busy", int'(busy), 0);
        check("reen_duty", int'(cur_duty), 0);

        // Asynchronous reset mid-ramp
        accept(8, 1'b0);
        wait_pe();
        check("ar_duty2", int'(cur_duty), 2);
        #2 rst = 1'b0;
        #1;
        check("ar_duty", int'(cur_duty), 0);
        check("ar_dout", int'(dout), 0);
        check("ar_ready", int'(tgt_ready), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_pe", int'(period_end), 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_off_dout", int'(dout), 0);
        check("ar_off_ready", int'(tgt_ready), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Duty-cycle sequencer and generator for the team's PWM output stage. A host requests a target duty via a valid/ready handshake. The block slews the applied duty toward that target by a fixed step once per PWM period, and changes the applied duty only at period boundaries so no runt pulses occur. It contains the period counter and compare stage and drives the `dout` pin directly.

## Interface
- `PERIOD`, 10: counts per PWM period; legal range ≥2.
- `DUTY_W`, 8: width of requested duty; must satisfy 2^DUTY_W > PERIOD.
- `STEP`, 2: maximum duty change per period; ≥1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run control; low forces output off.
- `tgt_valid`  in  1  host target request valid.
- `tgt_duty`  in  DUTY_W  requested high-count per period.
- `tgt_ready`  out  1  block can accept a target.
- `dout`  out  1  PWM output.
- `cur_duty`  out  DUTY_W  duty currently applied.
- `busy`  out  1  ramp in progress.
- `period_end`  out  1  high during the last count of each period.

## Operation
- Counter `cnt` (width CNT_W = $clog2(PERIOD)): when enable=1, counts 0..PERIOD-1 and wraps to 0. When enable=0, it is held at 0.
- `period_end` = enable && (cnt == PERIOD-1).
- `dout` = enable && (cnt < cur_duty). It is decoded from registers only.
  - cur_duty=0 gives a constant low output.
  - cur_duty=PERIOD gives a constant high output.
- Target capture: on a clock edge with tgt_valid && tgt_ready, the target register is loaded with min(tgt_duty, PERIOD).
- FSM states:
  - **OFF**: entered from any state when enable=0. Clears cur_duty and target to 0; tgt_ready=0.
  - **IDLE**: tgt_ready=1, busy=0.
    - Accept with clamped target ≠ cur_duty: go to RAMP.
    - Accept with clamped target = cur_duty: stay in IDLE.
    - enable=0: go to OFF.
  - **RAMP**: tgt_ready=0, busy=1.
    - On each period_end edge, cur_duty moves toward the target by min(STEP, |target − cur_duty|).
    - On the edge where cur_duty reaches the target, go to IDLE.
    - enable=0: go to OFF.
  - From OFF, enable=1 moves the FSM to IDLE.
- Arithmetic: compute the difference one bit wider than DUTY_W (unsigned compare, then subtract). Never underflow below 0 or exceed PERIOD.
- Requests are not queued. While in RAMP or OFF, tgt_valid is ignored and must be held by the host.

## Timing
- Reset values: cnt=0, cur_duty=0, target=0, state=OFF, dout=0, tgt_ready=0, busy=0, period_end=0.
- After an accept, RAMP is entered on the next edge. The first duty change occurs at the next period_end edge, never on the accept edge, even if period_end is high in that cycle.
- A new cur_duty first affects `dout` at cnt=0 of the following period.
- Ramp length: ceil(|target − start| / STEP) periods.
- After the final step, tgt_ready rises in the cycle after the last period_end edge.
- enable falling mid-period: the next edge clears cnt and cur_duty, so dout=0 from that cycle. The FSM enters OFF and any ramp is abandoned.
- Async reset asserted mid-ramp: all state returns to reset values immediately, independent of clk.

## Structure
- Shared package `pwm_pkg` holds:
  - state enum `pwm_state_t` {OFF, IDLE, RAMP};
  - a helper function `sat_step(cur, tgt, step)` returning the next duty.
- Sub-module `pwm_core` holds the counter, period_end and compare, with inputs enable and cur_duty.
- The FSM, target register and handshake live in the top level.

## Test plan
- **Reset:** assert rst=0 mid-run. All outputs are 0 and tgt_ready=0 immediately. After release with enable=0, dout stays 0 and the FSM stays in OFF.
- **Ramp up:** enable=1, accept tgt_duty=6.
  - cur_duty goes 0→2→4→6 over 3 period_end edges.
  - busy is high throughout; tgt_ready is high one cycle after the 3rd period_end.
  - dout is then high for cnt 0..5, i.e. 6 of 10 cycles.
- **Clamp:** accept tgt_duty=15. The target is 10; the ramp reaches 10 and dout becomes constant high with no low cycle.
- **Ramp down, partial step:** from cur_duty=6, accept tgt_duty=1. cur_duty goes 6→4→2→1.
- **Handshake stall:** hold tgt_valid=1 with tgt_duty=3 during a ramp. Not accepted until IDLE; then captured in the first cycle tgt_ready=1. Accepting tgt_duty equal to cur_duty leaves busy=0.
- **Enable drop mid-period:** during a ramp at cnt=4, drop enable.
  - Next edge: cnt=0, cur_duty=0, dout=0, FSM in OFF.
  - Re-enable: FSM in IDLE with cur_duty=0.
